// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and flush.
// Ports: clk/reset(async, high), hold, flush, id_* in, ex_* out, stall, ctrl_enable,
// bubble_cnt (counts bubbles only when ID_EX_STALL_CNT_EN is defined, else tied to 0).
module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  flush,
  input  logic [12:0]           id_ctrl,
  input  logic [DATA_W-1:0]     id_pc4,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [4:0]            id_shamt,
  input  logic [5:0]            id_funct,
  output logic [12:0]           ex_ctrl,
  output logic [DATA_W-1:0]     ex_pc4,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [4:0]            ex_shamt,
  output logic [5:0]            ex_funct,
  output logic                  stall,
  output logic                  ctrl_enable,
  output logic [31:0]           bubble_cnt
);

  localparam int MEMREAD_BIT = 10;

  logic [12:0]           ctrl_q, ctrl_d;
  logic [DATA_W-1:0]     pc4_q, pc4_d;
  logic [DATA_W-1:0]     rd1_q, rd1_d;
  logic [DATA_W-1:0]     rd2_q, rd2_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [4:0]            shamt_q, shamt_d;
  logic [5:0]            funct_q, funct_d;

  logic haz;
  logic bubble;

  // A load in EX whose destination feeds the ID instruction; $zero never counts.
  assign haz = ctrl_q[MEMREAD_BIT] & (rt_q != '0) &
               ((rt_q == id_rs) | (rt_q == id_rt));

  // A squashed ID instruction must not freeze the fetch redirect.
  assign stall       = haz & ~flush & ~hold;
  assign ctrl_enable = ~stall;
  assign bubble      = ~hold & (haz | flush);

  always_comb begin
    ctrl_d  = ctrl_q;
    pc4_d   = pc4_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    shamt_d = shamt_q;
    funct_d = funct_q;
    if (!hold) begin
      // Reserved bit 0 is always registered as zero.
      ctrl_d  = bubble ? '0 : {id_ctrl[12:1], id_ctrl[0] & 1'b0};
      pc4_d   = id_pc4;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      shamt_d = id_shamt;
      funct_d = id_funct;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_q  <= '0;
      pc4_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      shamt_q <= '0;
      funct_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      pc4_q   <= pc4_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      shamt_q <= shamt_d;
      funct_q <= funct_d;
    end
  end

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  // Wraps naturally at 2^32.
  always_comb begin
    cnt_d = cnt_q;
    if (bubble) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

  assign ex_ctrl  = ctrl_q;
  assign ex_pc4   = pc4_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_rd    = rd_q;
  assign ex_shamt = shamt_q;
  assign ex_funct = funct_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed load-use/flush/hold/reset cases, then random traffic
// checked every cycle against a behavioural model of the ID/EX register.
module tb_id_ex_stage;

`ifdef ID_EX_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hold = 1'b0;
  logic        flush = 1'b0;
  logic [12:0] id_ctrl = '0;
  logic [31:0] id_pc4 = '0, id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, id_shamt = '0;
  logic [5:0]  id_funct = '0;
  logic [12:0] ex_ctrl;
  logic [31:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]  ex_funct;
  logic        stall, ctrl_enable;
  logic [31:0] bubble_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  localparam logic [12:0] RTYPE = 13'h1044;
  localparam logic [12:0] LW    = 13'h06C0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .hold(hold), .flush(flush),
    .id_ctrl(id_ctrl), .id_pc4(id_pc4), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_shamt(id_shamt), .id_funct(id_funct),
    .ex_ctrl(ex_ctrl), .ex_pc4(ex_pc4), .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct),
    .stall(stall), .ctrl_enable(ctrl_enable), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what EX should hold is simply "last ID instruction accepted",
  // with its control word replaced by zero whenever it was squashed.
  logic [12:0] m_ctrl;
  logic [31:0] m_pc4, m_rd1, m_rd2, m_imm, m_cnt;
  logic [4:0]  m_rs, m_rt, m_rd, m_shamt;
  logic [5:0]  m_funct;

  function automatic bit load_use();
    bit ex_is_load;
    ex_is_load = m_ctrl[10];
    return ex_is_load && m_rt != 0 && (m_rt == id_rs || m_rt == id_rt);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ctrl = 0; m_pc4 = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
      m_rs = 0; m_rt = 0; m_rd = 0; m_shamt = 0; m_funct = 0; m_cnt = 0;
    end else if (!hold) begin
      bit squash;
      squash = flush || load_use();
      if (squash && CNT_EN) m_cnt = m_cnt + 1;
      m_ctrl = squash ? 13'd0 : (id_ctrl & 13'h1FFE);
      m_pc4 = id_pc4; m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_shamt = id_shamt; m_funct = id_funct;
    end
  end

  // Compare process: inputs change only at negedge, so +2 is settled.
  always @(negedge clk) begin
    #2;
    if (chk_en && !reset) begin
      chk("ctrl", ex_ctrl, m_ctrl);
      chk("pc4", ex_pc4, m_pc4);
      chk("rd1", ex_rd1, m_rd1);
      chk("rd2", ex_rd2, m_rd2);
      chk("imm", ex_imm, m_imm);
      chk("rs", ex_rs, m_rs);
      chk("rt", ex_rt, m_rt);
      chk("rd", ex_rd, m_rd);
      chk("shamt", ex_shamt, m_shamt);
      chk("funct", ex_funct, m_funct);
      chk("stall", stall, load_use() && !flush && !hold);
      chk("ctrl_enable", ctrl_enable, !(load_use() && !flush && !hold));
      chk("bubble_cnt", bubble_cnt, m_cnt);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input logic [12:0] c, input logic [4:0] rs,
                     input logic [4:0] rt);
    id_ctrl = c; id_rs = rs; id_rt = rt;
  endtask

  initial begin
    #1;
    chk("rst_ctrl", ex_ctrl, 13'd0);
    chk("rst_stall", stall, 1'b0);
    chk("rst_en", ctrl_enable, 1'b1);
    chk("rst_cnt", bubble_cnt, 32'd0);
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // Pass-through of an R-type instruction.
    put(RTYPE, 5'd1, 5'd2);
    id_rd1 = 32'h12345678; id_rd = 5'd9; id_funct = 6'h20;
    #1 chk("t2_stall", stall, 1'b0);
    tick();
    chk("t2_ctrl", ex_ctrl, 13'h1044);
    chk("t2_rd1", ex_rd1, 32'h12345678);
    chk("t2_rd", ex_rd, 5'd9);

    // Load-use: lw writes r5, next instruction reads r5.
    put(LW, 5'd1, 5'd5);
    tick();
    put(RTYPE, 5'd5, 5'd3);
    #1 chk("t3_stall", stall, 1'b1);
    chk("t3_en", ctrl_enable, 1'b0);
    tick();
    chk("t3_bubble", ex_ctrl, 13'd0);
    chk("t3_stall_clr", stall, 1'b0);
    chk("t3_cnt", bubble_cnt, CNT_EN ? 32'd1 : 32'd0);

    // $zero destination and a non-matching load.
    put(LW, 5'd1, 5'd0);
    tick();
    put(RTYPE, 5'd0, 5'd0);
    #1 chk("t4_zero", stall, 1'b0);
    tick();
    chk("t4_zero_cap", ex_ctrl, 13'h1044);
    put(LW, 5'd1, 5'd5);
    tick();
    put(RTYPE, 5'd6, 5'd7);
    #1 chk("t4_nomatch", stall, 1'b0);
    tick();
    chk("t4_nm_cap", ex_ctrl, 13'h1044);

    // Flush wins over the hazard.
    put(LW, 5'd1, 5'd5);
    tick();
    put(RTYPE, 5'd5, 5'd3);
    flush = 1'b1;
    #1 chk("t5_stall", stall, 1'b0);
    tick();
    flush = 1'b0;
    chk("t5_ctrl", ex_ctrl, 13'd0);
    chk("t5_cnt", bubble_cnt, CNT_EN ? 32'd2 : 32'd0);

    // Hold freezes everything; bubble goes in once hold drops.
    put(LW, 5'd1, 5'd5);
    tick();
    put(RTYPE, 5'd5, 5'd3);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t6_stall", stall, 1'b0);
      tick();
      chk("t6_ctrl", ex_ctrl, 13'h06C0);
      chk("t6_rt", ex_rt, 5'd5);
      chk("t6_cnt", bubble_cnt, CNT_EN ? 32'd2 : 32'd0);
    end
    hold = 1'b0;
    #1 chk("t6_stall_rel", stall, 1'b1);
    tick();
    chk("t6_bubble", ex_ctrl, 13'd0);
    chk("t6_cnt2", bubble_cnt, CNT_EN ? 32'd3 : 32'd0);

    // Reset mid-stall clears outputs and stall without an edge.
    put(LW, 5'd1, 5'd5);
    id_rd1 = 32'hDEADBEEF;
    tick();
    put(RTYPE, 5'd5, 5'd3);
    #1 chk("t1_pre", stall, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("t1_ctrl", ex_ctrl, 13'd0);
    chk("t1_rt", ex_rt, 5'd0);
    chk("t1_rd1", ex_rd1, 32'd0);
    chk("t1_stall", stall, 1'b0);
    chk("t1_en", ctrl_enable, 1'b1);
    chk("t1_cnt", bubble_cnt, 32'd0);
    reset = 1'b0;
    tick();

    // Random traffic, biased toward small register numbers and loads.
    for (int n = 0; n < 3000; n++) begin
      id_ctrl  = 13'($urandom);
      if ($urandom_range(0, 1) == 0) id_ctrl[10] = 1'b1;
      id_rs    = 5'($urandom_range(0, 3));
      id_rt    = 5'($urandom_range(0, 3));
      id_rd    = 5'($urandom);
      id_pc4   = $urandom;
      id_rd1   = $urandom;
      id_rd2   = $urandom;
      id_imm   = $urandom;
      id_shamt = 5'($urandom);
      id_funct = 6'($urandom);
      flush    = ($urandom_range(0, 9) == 0);
      hold     = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #3 reset = 1'b1;
        #1 reset = 1'b0;
      end
      tick();
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
